wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: takes the latched MemData/WBType/WBData/MemRead/RegWrite/Rd and retires the instruction.
- Selects load data or ALU/link data, sign/zero-extends sub-word loads, and writes the 32x32 GPR file.
- Provides ID-stage read ports with write-through bypass, plus a WB-stage forwarding tap for the hazard unit.
- Also holds a retired-write counter and a registered misaligned-load flag.

Parameters:
- NREG, 32, number of GPRs; address width = $clog2(NREG)
- DW, 32, data width
- CNTW, 32, retire counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  active-low asynchronous reset
- MemData  in  DW  aligned word read from data memory (MEM/WB output)
- WBType  in  4  writeback type (encoding below)
- WBData  in  DW  ALU/link result; load effective address when MemRead=1
- MemRead  in  1  instruction is a load
- RegWrite  in  1  instruction writes a GPR
- Rd  in  5  destination register
- rs_addr  in  5  ID read port A address
- rt_addr  in  5  ID read port B address
- rs_data  out  DW  read port A data
- rt_data  out  DW  read port B data
- wb_en  out  1  forwarding tap: a GPR write is happening this cycle
- wb_addr  out  5  forwarding tap: destination register
- wb_value  out  DW  forwarding tap: final write value
- align_err  out  1  registered one-cycle pulse on a misaligned load
- retire_count  out  CNTW  count of committed GPR writes

Behaviour:
Interface:
- One clock, clk.
- Reset rst_n is asynchronous and active-low.
- All state updates on posedge clk.

Reset:
- All GPRs = 0, retire_count = 0, align_err = 0.
- wb_en/wb_addr/wb_value are combinational from inputs.

WBType encoding (used only when MemRead=1; ignored otherwise):
- 0 = LW, 1 = LB, 2 = LBU, 3 = LH, 4 = LHU.
- 5..15 are reserved and treated as LW.
- Little-endian; byte offset off = WBData[1:0].

Load extraction:
- LB/LBU: byte MemData[8*off +: 8], then sign-/zero-extended.
- LH/LHU: half MemData[16*off[1] +: 16], then sign-/zero-extended.
- LW: MemData unchanged.

Value selection:
- wb_value = extracted load value if MemRead=1, else WBData.
- wb_en = RegWrite && (Rd != 0); wb_addr = Rd.

Write:
- At posedge, if wb_en then GPR[Rd] <= wb_value.
- GPR[0] is never written and always reads 0.

Reads (combinational):
- rs_data = 0 if rs_addr == 0.
- Else wb_value if wb_en && rs_addr == Rd (write-through, same cycle).
- Else GPR[rs_addr]. rt_data is identical on rt_addr.

Latency:
- Write is visible at the read ports combinationally in the same cycle (bypass), and from storage from the next cycle.

Misalignment:
- A misaligned load is MemRead && RegWrite && ((LH/LHU with off[0]=1) || (LW with off != 0)).
- align_err <= 1 for exactly the next cycle; otherwise align_err <= 0.
- The write still commits using the extraction rules above (address bits below alignment are ignored); no trap.

Counter:
- retire_count increments by 1 on each cycle where wb_en = 1.
- Wraps modulo 2^CNTW.
- A write to r0 does not count.

Bubbles:
- A flushed MEM/WB presents all-zero inputs, so RegWrite=0: no write, no count, no align_err.

Reset mid-operation:
- An asserted rst_n overrides a pending write; that write is lost.
- After deassertion, the first posedge behaves normally.

Decomposition:
- Shared package pipe_pkg holds:
  - WBType localparams (WB_LW, WB_LB, WB_LBU, WB_LH, WB_LHU);
  - REG_ZERO = 5'd0;
  - the DW and address-width constants.
- One natural sub-module, load_extract: purely combinational (MemData, WBType, off) -> 32-bit value, plus a misalign flag.
- Register array, bypass, counter and align_err register live in the top.

Test Plan:
- Reset: assert rst_n=0 mid-stream, release -> every rs/rt read returns 0, retire_count=0, align_err=0.
- ALU write with bypass: RegWrite=1, MemRead=0, Rd=5, WBData=32'hDEADBEEF, rs_addr=5 in the same cycle -> rs_data=32'hDEADBEEF combinationally. Next cycle with RegWrite=0 -> still 32'hDEADBEEF; retire_count=1.
- Sub-word loads: MemData=32'h8081_7F80.
  - LB, WBData=...01 -> 32'h0000007F.
  - LB, off=0 -> 32'hFFFFFF80.
  - LBU, off=3 -> 32'h00000080.
  - LH, off=2 -> 32'hFFFF8081.
  - LHU, off=0 -> 32'h00007F80.
- r0 protection: RegWrite=1, Rd=0, WBData=32'h1234 -> rs_data at addr 0 is 0, wb_en=0, retire_count unchanged.
- Misaligned: LW with WBData=32'h1003, Rd=7 -> align_err=1 for exactly one cycle after the edge; GPR7 = MemData; retire_count increments.
- Counter wrap (CNTW=4): 17 consecutive writes to Rd=1 -> retire_count=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared writeback-stage constants and load type encodings
package pipe_pkg;

   localparam int DATA_W = 32;
   localparam int NUM_REG = 32;
   localparam int ADDR_W = $clog2(NUM_REG);

   localparam logic [3:0] WB_LW  = 4'd0;
   localparam logic [3:0] WB_LB  = 4'd1;
   localparam logic [3:0] WB_LBU = 4'd2;
   localparam logic [3:0] WB_LH  = 4'd3;
   localparam logic [3:0] WB_LHU = 4'd4;

   localparam logic [4:0] REG_ZERO = 5'd0;

   function automatic logic is_half_load(input logic [3:0] wb_type);
      return (wb_type == WB_LH) || (wb_type == WB_LHU);
   endfunction

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - little-endian sub-word load extraction and misalign detect
module load_extract
   import pipe_pkg::*;
#(
   parameter int DW = DATA_W
) (
   input  logic [DW-1:0] mem_data,
   input  logic [3:0]    wb_type,
   input  logic [1:0]    off,
   output logic [DW-1:0] value,
   output logic          misalign
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign byte_v = mem_data[{off, 3'b000} +: 8];
   assign half_v = mem_data[{off[1], 4'b0000} +: 16];

   // Reserved encodings fall into the default arm and behave as a full-word load.
   always_comb begin
      value    = mem_data;
      misalign = 1'b0;
      case (wb_type)
         WB_LB:   value = {{(DW-8){byte_v[7]}}, byte_v};
         WB_LBU:  value = {{(DW-8){1'b0}}, byte_v};
         WB_LH: begin
            value    = {{(DW-16){half_v[15]}}, half_v};
            misalign = off[0];
         end
         WB_LHU: begin
            value    = {{(DW-16){1'b0}}, half_v};
            misalign = off[0];
         end
         default: begin
            value    = mem_data;
            misalign = (off != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MEM/WB retirement: value select, GPR file with bypass, retire counter
module wb_regfile
   import pipe_pkg::*;
#(
   parameter int NREG = 32,
   parameter int DW   = 32,
   parameter int CNTW = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [DW-1:0]   MemData,
   input  logic [3:0]      WBType,
   input  logic [DW-1:0]   WBData,
   input  logic            MemRead,
   input  logic            RegWrite,
   input  logic [4:0]      Rd,
   input  logic [4:0]      rs_addr,
   input  logic [4:0]      rt_addr,
   output logic [DW-1:0]   rs_data,
   output logic [DW-1:0]   rt_data,
   output logic            wb_en,
   output logic [4:0]      wb_addr,
   output logic [DW-1:0]   wb_value,
   output logic            align_err,
   output logic [CNTW-1:0] retire_count
);

   localparam int AW = $clog2(NREG);

   logic [DW-1:0] gpr [NREG];
   logic [DW-1:0] load_val;
   logic          load_misalign;

   load_extract #(.DW(DW)) u_extract (
      .mem_data (MemData),
      .wb_type  (WBType),
      .off      (WBData[1:0]),
      .value    (load_val),
      .misalign (load_misalign)
   );

   assign wb_en    = RegWrite && (Rd != REG_ZERO);
   assign wb_addr  = Rd;
   assign wb_value = MemRead ? load_val : WBData;

   // The in-flight write wins over storage so ID sees it in the same cycle.
   always_comb begin
      rs_data = '0;
      if (rs_addr != REG_ZERO) begin
         if (wb_en && (rs_addr == Rd))
            rs_data = wb_value;
         else
            rs_data = gpr[rs_addr[AW-1:0]];
      end
   end

   always_comb begin
      rt_data = '0;
      if (rt_addr != REG_ZERO) begin
         if (wb_en && (rt_addr == Rd))
            rt_data = wb_value;
         else
            rt_data = gpr[rt_addr[AW-1:0]];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++)
            gpr[i] <= '0;
      end else if (wb_en) begin
         gpr[Rd[AW-1:0]] <= wb_value;
      end
   end

   // Misaligned loads still commit; the flag is only an observation pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_count <= '0;
         align_err    <= 1'b0;
      end else begin
         align_err <= MemRead && RegWrite && load_misalign;
         if (wb_en)
            retire_count <= retire_count + CNTW'(1);
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed self-checking bench for wb_regfile
module tb_wb_regfile;

   logic        clk;
   logic        rst_n;
   logic [31:0] MemData;
   logic [3:0]  WBType;
   logic [31:0] WBData;
   logic        MemRead;
   logic        RegWrite;
   logic [4:0]  Rd;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_value;
   logic        align_err;
   logic [3:0]  retire_count;

   int n_cmp;
   int n_mis;
   logic [3:0] exp_cnt;

   wb_regfile #(.NREG(32), .DW(32), .CNTW(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .MemData      (MemData),
      .WBType       (WBType),
      .WBData       (WBData),
      .MemRead      (MemRead),
      .RegWrite     (RegWrite),
      .Rd           (Rd),
      .rs_addr      (rs_addr),
      .rt_addr      (rt_addr),
      .rs_data      (rs_data),
      .rt_data      (rt_data),
      .wb_en        (wb_en),
      .wb_addr      (wb_addr),
      .wb_value     (wb_value),
      .align_err    (align_err),
      .retire_count (retire_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic rw, input logic mr, input logic [3:0] t,
                        input logic [4:0] rd, input logic [31:0] wbd, input logic [31:0] md);
      RegWrite = rw;
      MemRead  = mr;
      WBType   = t;
      Rd       = rd;
      WBData   = wbd;
      MemData  = md;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 4'd0, 5'd0, 32'h0, 32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 4'd0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      drive(1'b1, 1'b0, 4'd0, 5'd3, 32'hAAAA_0003, 32'h0);
      @(negedge clk);
      // Reset lands while a write to r4 is pending; that write must be lost.
      drive(1'b1, 1'b0, 4'd0, 5'd4, 32'h5555_0004, 32'h0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      exp_cnt = 4'd0;
      for (int i = 0; i < 32; i++) begin
         rs_addr = 5'(i);
         rt_addr = 5'(31 - i);
         #1;
         n_cmp++;
         if (rs_data !== 32'h0) begin
            n_mis++;
            $display("FAIL reset_rs[%0d]: got %h expected %h", i, rs_data, 32'h0);
         end
         n_cmp++;
         if (rt_data !== 32'h0) begin
            n_mis++;
            $display("FAIL reset_rt[%0d]: got %h expected %h", 31 - i, rt_data, 32'h0);
         end
      end
      n_cmp++;
      if (retire_count !== 4'd0) begin
         n_mis++;
         $display("FAIL reset_count: got %0d expected 0", retire_count);
      end
      n_cmp++;
      if (align_err !== 1'b0) begin
         n_mis++;
         $display("FAIL reset_align: got %b expected 0", align_err);
      end
   endtask

   task automatic test_alu_bypass();
      @(negedge clk);
      drive(1'b1, 1'b0, 4'd0, 5'd5, 32'hDEAD_BEEF, 32'h1111_1111);
      rs_addr = 5'd5;
      rt_addr = 5'd6;
      #1;
      n_cmp++;
      if (rs_data !== 32'hDEAD_BEEF) begin
         n_mis++;
         $display("FAIL alu_bypass_rs: got %h expected %h", rs_data, 32'hDEAD_BEEF);
      end
      n_cmp++;
      if (rt_data !== 32'h0) begin
         n_mis++;
         $display("FAIL alu_bypass_rt: got %h expected %h", rt_data, 32'h0);
      end
      n_cmp++;
      if ({wb_en, wb_addr, wb_value} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
         n_mis++;
         $display("FAIL alu_tap: got %b/%0d/%h expected 1/5/deadbeef", wb_en, wb_addr, wb_value);
      end
      @(posedge clk);
      exp_cnt = exp_cnt + 4'd1;
      @(negedge clk);
      idle();
      #1;
      n_cmp++;
      if (rs_data !== 32'hDEAD_BEEF) begin
         n_mis++;
         $display("FAIL alu_stored: got %h expected %h", rs_data, 32'hDEAD_BEEF);
      end
      n_cmp++;
      if (retire_count !== exp_cnt) begin
         n_mis++;
         $display("FAIL alu_count: got %0d expected %0d", retire_count, exp_cnt);
      end
   endtask

   task automatic test_loads();
      logic [3:0]  t_tab [9];
      logic [31:0] a_tab [9];
      logic [31:0] e_tab [9];
      t_tab = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd9, 4'd4, 4'd1};
      a_tab = '{32'h0000_2001, 32'h0000_2000, 32'h0000_2003, 32'h0000_2002, 32'h0000_2000,
                32'h0000_2000, 32'h0000_2004, 32'h0000_2002, 32'h0000_2002};
      e_tab = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8081, 32'h0000_7F80,
                32'h8081_7F80, 32'h8081_7F80, 32'h0000_8081, 32'hFFFF_FF81};
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         drive(1'b1, 1'b1, t_tab[i], 5'(10 + i), a_tab[i], 32'h8081_7F80);
         rs_addr = 5'(10 + i);
         #1;
         n_cmp++;
         if (wb_value !== e_tab[i]) begin
            n_mis++;
            $display("FAIL load_value[%0d]: got %h expected %h", i, wb_value, e_tab[i]);
         end
         n_cmp++;
         if (rs_data !== e_tab[i]) begin
            n_mis++;
            $display("FAIL load_bypass[%0d]: got %h expected %h", i, rs_data, e_tab[i]);
         end
         @(posedge clk);
         exp_cnt = exp_cnt + 4'd1;
         #1;
         n_cmp++;
         if (align_err !== 1'b0) begin
            n_mis++;
            $display("FAIL load_align[%0d]: got %b expected 0", i, align_err);
         end
      end
      @(negedge clk);
      idle();
      for (int i = 0; i < 9; i++) begin
         rt_addr = 5'(10 + i);
         #1;
         n_cmp++;
         if (rt_data !== e_tab[i]) begin
            n_mis++;
            $display("FAIL load_stored[%0d]: got %h expected %h", i, rt_data, e_tab[i]);
         end
      end
      n_cmp++;
      if (retire_count !== exp_cnt) begin
         n_mis++;
         $display("FAIL load_count: got %0d expected %0d", retire_count, exp_cnt);
      end
   endtask

   task automatic test_r0();
      @(negedge clk);
      drive(1'b1, 1'b0, 4'd0, 5'd0, 32'h0000_1234, 32'h0);
      rs_addr = 5'd0;
      rt_addr = 5'd0;
      #1;
      n_cmp++;
      if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
         n_mis++;
         $display("FAIL r0_bypass: got %h/%h expected 0/0", rs_data, rt_data);
      end
      n_cmp++;
      if (wb_en !== 1'b0) begin
         n_mis++;
         $display("FAIL r0_wb_en: got %b expected 0", wb_en);
      end
      @(negedge clk);
      idle();
      #1;
      n_cmp++;
      if (rs_data !== 32'h0) begin
         n_mis++;
         $display("FAIL r0_stored: got %h expected 0", rs_data);
      end
      n_cmp++;
      if (retire_count !== exp_cnt) begin
         n_mis++;
         $display("FAIL r0_count: got %0d expected %0d", retire_count, exp_cnt);
      end
   endtask

   task automatic test_misalign();
      @(negedge clk);
      drive(1'b1, 1'b1, 4'd0, 5'd7, 32'h0000_1003, 32'h8081_7F80);
      #1;
      n_cmp++;
      if (align_err !== 1'b0) begin
         n_mis++;
         $display("FAIL mis_pre: got %b expected 0", align_err);
      end
      @(posedge clk);
      exp_cnt = exp_cnt + 4'd1;
      #1;
      n_cmp++;
      if (align_err !== 1'b1) begin
         n_mis++;
         $display("FAIL mis_lw_pulse: got %b expected 1", align_err);
      end
      @(negedge clk);
      idle();
      rs_addr = 5'd7;
      @(posedge clk);
      #1;
      n_cmp++;
      if (align_err !== 1'b0) begin
         n_mis++;
         $display("FAIL mis_lw_clear: got %b expected 0", align_err);
      end
      n_cmp++;
      if (rs_data !== 32'h8081_7F80) begin
         n_mis++;
         $display("FAIL mis_lw_data: got %h expected %h", rs_data, 32'h8081_7F80);
      end
      n_cmp++;
      if (retire_count !== exp_cnt) begin
         n_mis++;
         $display("FAIL mis_count: got %0d expected %0d", retire_count, exp_cnt);
      end
      // LH at odd offset: low half is still taken, flag pulses.
      @(negedge clk);
      drive(1'b1, 1'b1, 4'd3, 5'd8, 32'h0000_2001, 32'h8081_7F80);
      #1;
      n_cmp++;
      if (wb_value !== 32'h0000_7F80) begin
         n_mis++;
         $display("FAIL mis_lh_value: got %h expected %h", wb_value, 32'h0000_7F80);
      end
      @(posedge clk);
      exp_cnt = exp_cnt + 4'd1;
      #1;
      n_cmp++;
      if (align_err !== 1'b1) begin
         n_mis++;
         $display("FAIL mis_lh_pulse: got %b expected 1", align_err);
      end
      // Misaligned load with RegWrite=0 raises nothing.
      @(negedge clk);
      drive(1'b0, 1'b1, 4'd0, 5'd9, 32'h0000_3002, 32'h8081_7F80);
      @(posedge clk);
      #1;
      n_cmp++;
      if (align_err !== 1'b0) begin
         n_mis++;
         $display("FAIL mis_norw: got %b expected 0", align_err);
      end
      n_cmp++;
      if (retire_count !== exp_cnt) begin
         n_mis++;
         $display("FAIL mis_norw_count: got %0d expected %0d", retire_count, exp_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v_tab [4];
      v_tab = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(1'b1, 1'b0, 4'd0, 5'(20 + i), v_tab[i], 32'h0);
         rs_addr = 5'(20 + i);
         rt_addr = (i == 0) ? 5'd5 : 5'(19 + i);
         #1;
         n_cmp++;
         if (rs_data !== v_tab[i]) begin
            n_mis++;
            $display("FAIL b2b_bypass[%0d]: got %h expected %h", i, rs_data, v_tab[i]);
         end
         n_cmp++;
         if (rt_data !== ((i == 0) ? 32'hDEAD_BEEF : v_tab[(i == 0) ? 0 : i - 1])) begin
            n_mis++;
            $display("FAIL b2b_prev[%0d]: got %h", i, rt_data);
         end
         @(posedge clk);
         exp_cnt = exp_cnt + 4'd1;
      end
      // Overwrite r5: bypass must win over the stored DEADBEEF.
      @(negedge clk);
      drive(1'b1, 1'b0, 4'd0, 5'd5, 32'hCAFE_F00D, 32'h0);
      rs_addr = 5'd5;
      #1;
      n_cmp++;
      if (rs_data !== 32'hCAFE_F00D) begin
         n_mis++;
         $display("FAIL b2b_override: got %h expected %h", rs_data, 32'hCAFE_F00D);
      end
      @(posedge clk);
      exp_cnt = exp_cnt + 4'd1;
      @(negedge clk);
      idle();
      #1;
      n_cmp++;
      if (retire_count !== exp_cnt) begin
         n_mis++;
         $display("FAIL b2b_count: got %0d expected %0d", retire_count, exp_cnt);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         drive(1'b1, 1'b0, 4'd0, 5'd1, 32'(i), 32'h0);
         @(posedge clk);
         #1;
         if (i == 15) begin
            n_cmp++;
            if (retire_count !== 4'd0) begin
               n_mis++;
               $display("FAIL wrap_16: got %0d expected 0", retire_count);
            end
         end
      end
      @(negedge clk);
      idle();
      rs_addr = 5'd1;
      #1;
      n_cmp++;
      if (retire_count !== 4'd1) begin
         n_mis++;
         $display("FAIL wrap_17: got %0d expected 1", retire_count);
      end
      n_cmp++;
      if (rs_data !== 32'd16) begin
         n_mis++;
         $display("FAIL wrap_data: got %h expected %h", rs_data, 32'd16);
      end
   endtask

   initial begin
      n_cmp   = 0;
      n_mis   = 0;
      exp_cnt = 4'd0;
      rst_n   = 1'b0;
      rs_addr = 5'd0;
      rt_addr = 5'd0;
      idle();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_alu_bypass();
      test_loads();
      test_r0();
      test_misalign();
      test_back_to_back();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
